// File: rtl/rs_pkg.sv
// rs_pkg: RS(544,522) over GF(2^10) constants, symbol type and field helpers.
package rs_pkg;
  localparam int RS_N = 544;
  localparam int RS_T = 11;
  localparam int RS_W = 10;
  localparam logic [RS_W:0] GF_POLY = 11'h409;
  typedef logic [RS_W-1:0] gf_t;
  localparam gf_t ALPHA_POW [0:22] = '{
    10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080,
    10'h100, 10'h200, 10'h009, 10'h012, 10'h024, 10'h048, 10'h090, 10'h120,
    10'h240, 10'h089, 10'h112, 10'h224, 10'h041, 10'h082, 10'h104};
  function automatic gf_t gf_xtime(gf_t v);
    return {v[RS_W-2:0], 1'b0} ^ (v[RS_W-1] ? GF_POLY[RS_W-1:0] : '0);
  endfunction
endpackage

// File: rtl/rs_syndrome_calc_s1_if.sv
// rs_syndrome_calc_s1_if: symbol stream in, syndrome vector out to the solver.
// RS_SYN_ZERO_FLAG_EN adds syn_zero_o.
interface rs_syndrome_calc_s1_if;
  import rs_pkg::*;
  gf_t  sym_i;
  logic sym_valid_i;
  logic sym_last_i;
  logic sym_ready_o;
  logic busy_i;
  gf_t  syn_o [0:2*RS_T];
  logic syn_valid_o;
  logic start_o;
  logic len_err_o;
`ifdef RS_SYN_ZERO_FLAG_EN
  logic syn_zero_o;
`endif
  modport slave (
`ifdef RS_SYN_ZERO_FLAG_EN
    output syn_zero_o,
`endif
    input  sym_i, sym_valid_i, sym_last_i, busy_i,
    output sym_ready_o, syn_o, syn_valid_o, start_o, len_err_o
  );
  modport master (
`ifdef RS_SYN_ZERO_FLAG_EN
    input  syn_zero_o,
`endif
    output sym_i, sym_valid_i, sym_last_i, busy_i,
    input  sym_ready_o, syn_o, syn_valid_o, start_o, len_err_o
  );
endinterface

// File: rtl/gf1024_cmul.sv
// gf1024_cmul: multiply by constant C in GF(2^10) as a fixed XOR matrix.
module gf1024_cmul import rs_pkg::*; #(
  parameter gf_t C = 10'h001
) (
  input  gf_t a_i,
  output gf_t y_o
);
  // column i is C*x^i reduced; constant after unrolling, so only XORs remain
  function automatic gf_t col(int i);
    gf_t v;
    v = C;
    for (int k = 0; k < i; k++) v = gf_xtime(v);
    return v;
  endfunction
  always_comb begin
    y_o = '0;
    for (int i = 0; i < RS_W; i++) y_o = y_o ^ (a_i[i] ? col(i) : '0);
  end
endmodule

// File: rtl/rs_syndrome_calc_s1.sv
// rs_syndrome_calc_s1: Horner syndrome accumulator with a one-frame output buffer.
// Define RS_SYN_ZERO_FLAG_EN to add the all-zero-syndrome flag syn_zero_o.
module rs_syndrome_calc_s1 import rs_pkg::*; (
  input logic clk_i,
  input logic rst_i,
  rs_syndrome_calc_s1_if.slave bus
);
  localparam int S = 2*RS_T;
  localparam logic [9:0] CNT_LAST = 10'(RS_N - 1);
  gf_t acc_q [1:S];
  gf_t acc_d [1:S];
  gf_t syn_q [1:S];
  gf_t syn_d [1:S];
  gf_t hor [1:S];
  logic [9:0] cnt_q, cnt_d;
  logic pend_q, pend_d, lerr_q, lerr_d;
  logic last, take;
  for (genvar j = 1; j <= S; j++) begin : g_cm
    gf_t m;
    gf1024_cmul #(.C(ALPHA_POW[j])) u_cm (.a_i(acc_q[j]), .y_o(m));
    assign hor[j] = m ^ bus.sym_i;
  end
  assign last = cnt_q == CNT_LAST;
  assign bus.sym_ready_o = ~(last & pend_q);
  assign take = bus.sym_valid_i & bus.sym_ready_o;
  assign bus.start_o = pend_q & ~bus.busy_i;
  assign bus.syn_valid_o = pend_q;
  assign bus.len_err_o = lerr_q;
  // take & last implies pend_q=0, so loading and handoff never coincide
  always_comb begin
    acc_d = acc_q;
    syn_d = syn_q;
    cnt_d = cnt_q;
    pend_d = pend_q & ~bus.start_o;
    lerr_d = take & (bus.sym_last_i != last);
    if (take) begin
      cnt_d = last ? '0 : cnt_q + 10'd1;
      pend_d = pend_d | last;
      for (int k = 1; k <= S; k++) begin
        acc_d[k] = last ? '0 : hor[k];
        syn_d[k] = last ? hor[k] : syn_q[k];
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 1; k <= S; k++) begin
        acc_q[k] <= '0;
        syn_q[k] <= '0;
      end
      cnt_q <= '0;
      pend_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      syn_q <= syn_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      lerr_q <= lerr_d;
    end
  end
  always_comb begin
    bus.syn_o[0] = '0;
    for (int k = 1; k <= S; k++) bus.syn_o[k] = syn_q[k];
  end
`ifdef RS_SYN_ZERO_FLAG_EN
  logic nz;
  always_comb begin
    nz = 1'b0;
    for (int k = 1; k <= S; k++) nz = nz | (|syn_q[k]);
  end
  assign bus.syn_zero_o = pend_q & ~nz;
`endif
endmodule

// File: tb/tb_rs_syndrome_calc_s1.sv
// tb_rs_syndrome_calc_s1: directed frames, expected syndromes queued and checked at each start_o.
module tb_rs_syndrome_calc_s1;
  import rs_pkg::*;
  typedef logic [22:1][9:0] vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rs_syndrome_calc_s1_if bus();
  rs_syndrome_calc_s1 dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  int starts = 0;
  int lerrs = 0;
  vec_t exp_q [$];
  vec_t mon_act, mon_exp;
  gf_t fr [0:543];
  gf_t a3 [1:22] = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100,
                     10'h200, 10'h009, 10'h012, 10'h024, 10'h048, 10'h090, 10'h120, 10'h240,
                     10'h089, 10'h112, 10'h224, 10'h041, 10'h082, 10'h104};

  function automatic gf_t gmul(gf_t a, gf_t b);
    logic [10:0] r;
    r = '0;
    for (int i = 9; i >= 0; i--) begin
      r = {r[9:0], 1'b0};
      if (r[10]) r = r ^ 11'h409;
      if (b[i]) r = r ^ {1'b0, a};
    end
    return r[9:0];
  endfunction

  function automatic vec_t golden();
    vec_t v;
    gf_t a, s;
    for (int j = 1; j <= 22; j++) begin
      a = 10'h001;
      for (int k = 0; k < j; k++) a = gmul(a, 10'h002);
      s = '0;
      for (int k = 0; k < 544; k++) s = gmul(s, a) ^ fr[k];
      v[j] = s;
    end
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic send(input gf_t s, input logic l);
    int n;
    n = 0;
    bus.sym_i = s;
    bus.sym_last_i = l;
    bus.sym_valid_i = 1'b1;
    #1;
    while (!bus.sym_ready_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n == 100) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int upto, input int extra_last);
    for (int k = 0; k < upto; k++) send(fr[k], k == 543 || k == extra_last);
    bus.sym_valid_i = 1'b0;
    bus.sym_last_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.start_o) begin
      starts++;
      for (int j = 1; j <= 22; j++) mon_act[j] = bus.syn_o[j];
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_start: got start with syn %h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL syndromes: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
    if (bus.len_err_o) lerrs++;
  end

  initial begin
    vec_t v;
    int s0;
    bus.sym_i = '0;
    bus.sym_valid_i = 1'b0;
    bus.sym_last_i = 1'b0;
    bus.busy_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_syn0", 32'(bus.syn_o[0]), 0);
    chk("rst_syn22", 32'(bus.syn_o[22]), 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.sym_ready_o), 1);
    chk("rst_valid", 32'(bus.syn_valid_o), 0);
    chk("rst_start", 32'(bus.start_o), 0);
    chk("rst_lenerr", 32'(bus.len_err_o), 0);
    @(negedge clk);
    // 1: all-zero frame
    for (int k = 0; k < 544; k++) fr[k] = '0;
    exp_q.push_back('0);
    send_frame(544, -1);
    chk("t1_start_latency", 32'(bus.start_o), 1);
    chk("t1_valid", 32'(bus.syn_valid_o), 1);
`ifdef RS_SYN_ZERO_FLAG_EN
    chk("t1_zero_flag", 32'(bus.syn_zero_o), 1);
`endif
    @(negedge clk);
    chk("t1_single_start", 32'(bus.start_o), 0);
    chk("t1_valid_clear", 32'(bus.syn_valid_o), 0);
    // 2: r0 = 1
    fr[543] = 10'h001;
    for (int j = 1; j <= 22; j++) v[j] = 10'h001;
    exp_q.push_back(v);
    send_frame(544, -1);
    @(negedge clk);
    // 3: r1 = 1
    fr[543] = '0;
    fr[542] = 10'h001;
    for (int j = 1; j <= 22; j++) v[j] = a3[j];
    exp_q.push_back(v);
    send_frame(544, -1);
    chk("t3_s1", 32'(bus.syn_o[1]), 32'h002);
    chk("t3_s10", 32'(bus.syn_o[10]), 32'h009);
    @(negedge clk);
    // 4: solver busy across two frames
    bus.busy_i = 1'b1;
    for (int k = 0; k < 544; k++) fr[k] = gf_t'((k * 7 + 3) & 10'h3ff);
    exp_q.push_back(golden());
    send_frame(544, -1);
    for (int k = 0; k < 544; k++) fr[k] = gf_t'(k * 13) ^ 10'h155;
    exp_q.push_back(golden());
    send_frame(543, -1);
    bus.sym_i = fr[543];
    bus.sym_last_i = 1'b1;
    bus.sym_valid_i = 1'b1;
    #1;
    chk("t4_backpressure", 32'(bus.sym_ready_o), 0);
    repeat (3) @(negedge clk);
    chk("t4_hold_ready", 32'(bus.sym_ready_o), 0);
    chk("t4_hold_valid", 32'(bus.syn_valid_o), 1);
    chk("t4_hold_nostart", 32'(bus.start_o), 0);
    bus.busy_i = 1'b0;
    #1;
    chk("t4_handoff_start", 32'(bus.start_o), 1);
    chk("t4_handoff_ready", 32'(bus.sym_ready_o), 0);
    send(fr[543], 1'b1);
    bus.sym_valid_i = 1'b0;
    bus.sym_last_i = 1'b0;
    chk("t4_second_start", 32'(bus.start_o), 1);
    @(negedge clk);
    chk("lenerr_none_yet", 32'(lerrs), 0);
    // 5: early sym_last
    for (int k = 0; k < 544; k++) fr[k] = gf_t'(k * 29) ^ 10'h2a5;
    exp_q.push_back(golden());
    send_frame(544, 100);
    repeat (2) @(negedge clk);
    chk("t5_lenerr_pulses", 32'(lerrs), 1);
    // 6: reset mid-frame
    s0 = starts;
    for (int k = 0; k < 544; k++) fr[k] = gf_t'($urandom_range(0, 1023));
    send_frame(300, -1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_no_start", 32'(starts), 32'(s0));
    chk("t6_valid", 32'(bus.syn_valid_o), 0);
    exp_q.push_back(golden());
    send_frame(544, -1);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("start_count", 32'(starts), 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
